// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: two-flop synchroniser, bit-centre sampling FSM and a
// single-entry valid/ready holding register with framing and overrun pulses.
module uart_rx_byte #(
  parameter logic [13:0] TMR_MAX = 14'd10416,
  parameter logic [13:0] HALF    = TMR_MAX >> 1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       UART_RX,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frm_err,
  output logic       overrun
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t      state_q, state_d;
  logic        sync1_q, rx_s;
  logic [13:0] tmr_q, tmr_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  sh_q, sh_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        frm_err_q, frm_err_d;
  logic        overrun_q, overrun_d;
  logic        deliver, tick, accept;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q    <= 1'b1;
      rx_s       <= 1'b1;
      state_q    <= IDLE;
      tmr_q      <= '0;
      idx_q      <= '0;
      sh_q       <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      frm_err_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      sync1_q    <= UART_RX;
      rx_s       <= sync1_q;
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      idx_q      <= idx_d;
      sh_q       <= sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      frm_err_q  <= frm_err_d;
      overrun_q  <= overrun_d;
    end
  end

  assign tick = (tmr_q == TMR_MAX);

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q + 14'd1;
    idx_d     = idx_q;
    sh_d      = sh_q;
    deliver   = 1'b0;
    frm_err_d = 1'b0;
    case (state_q)
      IDLE:  if (!rx_s) state_d = START;
      START: if (tmr_q == HALF) state_d = rx_s ? IDLE : DATA;
      DATA: begin
        // Timer wraps at every bit centre so samples stay one period apart.
        if (tick) begin
          sh_d  = {rx_s, sh_q[7:1]};
          idx_d = idx_q + 3'd1;
          tmr_d = '0;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (rx_s) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            frm_err_d = 1'b1;
            state_d   = BREAK;
          end
        end
      end
      BREAK:   if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) tmr_d = '0;
  end

  assign accept = rx_valid_q & rx_ready;

  always_comb begin
    rx_valid_d = rx_valid_q & ~accept;
    rx_data_d  = rx_data_q;
    overrun_d  = 1'b0;
    if (deliver) begin
      // A byte leaving on this edge frees the slot for the new one.
      if (!rx_valid_q || accept) begin
        rx_data_d  = sh_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign frm_err  = frm_err_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte with a 16-cycle bit period; a negedge
// monitor logs handshakes and pulses, each scenario compares against its model.
module tb_uart_rx_byte;

  localparam int BIT = 16;
  localparam int LAT = 3 + 7 + 9 * BIT;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       UART_RX = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic       frm_err;
  logic       overrun;

  int n_checks = 0;
  int n_errs   = 0;

  int          cyc = 0;
  logic [7:0]  hs_q[$];
  int          n_frm = 0;
  int          n_ovr = 0;
  int          rise_cyc = -1;
  logic        vld_prev = 1'b0;

  uart_rx_byte #(.TMR_MAX(14'd15), .HALF(14'd7)) dut (
    .CLK(CLK), .RST_N(RST_N), .UART_RX(UART_RX), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .frm_err(frm_err), .overrun(overrun)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (RST_N) begin
      if (rx_valid && rx_ready) hs_q.push_back(rx_data);
      if (frm_err) n_frm++;
      if (overrun) n_ovr++;
      if (rx_valid && !vld_prev) rise_cyc = cyc;
    end
    vld_prev = rx_valid;
  end

  task automatic idle(input int n);
    UART_RX = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  task automatic clear_log();
    hs_q.delete();
    n_frm = 0;
    n_ovr = 0;
    rise_cyc = -1;
  endtask

  // Whole frame, starting and ending on a negedge; returns e0.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int e0);
    e0 = cyc + 1;
    UART_RX = 1'b0;
    repeat (BIT) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      UART_RX = b[i];
      repeat (BIT) @(negedge CLK);
    end
    UART_RX = stop_bit;
    repeat (BIT) @(negedge CLK);
    UART_RX = 1'b1;
  endtask

  task automatic check_hs(input string name, input logic [7:0] exp_q[$]);
    n_checks++;
    if (hs_q.size() != exp_q.size()) begin
      n_errs++;
      $display("FAIL %s count: got %0d expected %0d", name, hs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (hs_q[i] !== exp_q[i]) begin
          n_errs++;
          $display("FAIL %s byte %0d: got %h expected %h", name, i, hs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic check_pulses(input string name, input int efrm, input int eovr);
    n_checks++;
    if (n_frm != efrm) begin
      n_errs++;
      $display("FAIL %s frm_err pulses: got %0d expected %0d", name, n_frm, efrm);
    end
    n_checks++;
    if (n_ovr != eovr) begin
      n_errs++;
      $display("FAIL %s overrun pulses: got %0d expected %0d", name, n_ovr, eovr);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    n_checks++;
    if ({rx_data, rx_valid, frm_err, overrun} !== 11'h0) begin
      n_errs++;
      $display("FAIL %s: got data=%h v=%b fe=%b ov=%b expected all zero",
               name, rx_data, rx_valid, frm_err, overrun);
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset");
    RST_N = 1'b1;
    idle(5);
    check_reset_outputs("post_reset_idle");
  endtask

  task automatic test_single();
    logic [7:0] exp_q[$];
    int e0;
    clear_log();
    rx_ready = 1'b1;
    send_frame(8'h54, 1'b1, e0);
    idle(10);
    n_checks++;
    if (rise_cyc - e0 != LAT) begin
      n_errs++;
      $display("FAIL single latency: got %0d expected %0d", rise_cyc - e0, LAT);
    end
    exp_q = '{8'h54};
    check_hs("single", exp_q);
    check_pulses("single", 0, 0);
    n_checks++;
    if (rx_valid !== 1'b0) begin
      n_errs++;
      $display("FAIL single valid_clear: got %b expected 0", rx_valid);
    end
  endtask

  task automatic test_string();
    logic [7:0] exp_q[$];
    int e0;
    clear_log();
    exp_q = '{8'h02, 8'h54, 8'h33, 8'h35, 8'h03};
    for (int i = 0; i < 6; i++) exp_q.push_back(8'($urandom_range(0, 255)));
    foreach (exp_q[i]) send_frame(exp_q[i], 1'b1, e0);
    idle(10);
    check_hs("string", exp_q);
    check_pulses("string", 0, 0);
  endtask

  task automatic test_glitch();
    logic [7:0] exp_q[$];
    int e0;
    clear_log();
    UART_RX = 1'b0;
    repeat (4) @(negedge CLK);
    idle(40);
    n_checks++;
    if (hs_q.size() != 0 || rise_cyc != -1) begin
      n_errs++;
      $display("FAIL glitch: got %0d bytes expected 0", hs_q.size());
    end
    send_frame(8'h33, 1'b1, e0);
    idle(10);
    exp_q = '{8'h33};
    check_hs("glitch_follow", exp_q);
  endtask

  task automatic test_framing();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int e0;
    clear_log();
    b = 8'($urandom_range(0, 255));
    send_frame(8'h33, 1'b0, e0);
    UART_RX = 1'b0;
    repeat (3 * BIT) @(negedge CLK);
    idle(20);
    check_hs("framing_none", exp_q);
    check_pulses("framing", 1, 0);
    send_frame(8'h35, 1'b1, e0);
    send_frame(b, 1'b1, e0);
    idle(10);
    exp_q = '{8'h35, b};
    check_hs("framing_follow", exp_q);
  endtask

  task automatic test_overrun();
    logic [7:0] exp_q[$];
    int e0;
    clear_log();
    rx_ready = 1'b0;
    send_frame(8'h35, 1'b1, e0);
    send_frame(8'h03, 1'b1, e0);
    idle(10);
    n_checks++;
    if (rx_data !== 8'h35 || rx_valid !== 1'b1) begin
      n_errs++;
      $display("FAIL overrun hold: got %h/%b expected 35/1", rx_data, rx_valid);
    end
    check_pulses("overrun", 0, 1);
    rx_ready = 1'b1;
    @(negedge CLK);
    rx_ready = 1'b0;
    idle(5);
    exp_q = '{8'h35};
    check_hs("overrun_drain", exp_q);
    n_checks++;
    if (rx_valid !== 1'b0) begin
      n_errs++;
      $display("FAIL overrun valid_clear: got %b expected 0", rx_valid);
    end

    // Accept exactly on the edge where the second byte is delivered.
    clear_log();
    send_frame(8'h35, 1'b1, e0);
    e0 = cyc + 1;
    fork
      send_frame(8'h03, 1'b1, e0);
      begin
        repeat (LAT) @(negedge CLK);
        rx_ready = 1'b1;
        @(negedge CLK);
        rx_ready = 1'b0;
      end
    join
    idle(10);
    n_checks++;
    if (rx_data !== 8'h03 || rx_valid !== 1'b1) begin
      n_errs++;
      $display("FAIL same_edge data: got %h/%b expected 03/1", rx_data, rx_valid);
    end
    check_pulses("same_edge", 0, 0);
    rx_ready = 1'b1;
    idle(5);
    exp_q = '{8'h35, 8'h03};
    check_hs("same_edge_drain", exp_q);
  endtask

  task automatic test_reset_mid_byte();
    logic [7:0] exp_q[$];
    int e0;
    clear_log();
    rx_ready = 1'b0;
    send_frame(8'h5A, 1'b1, e0);
    idle(4);
    UART_RX = 1'b0;
    repeat (BIT) @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      UART_RX = i[0];
      repeat (BIT) @(negedge CLK);
    end
    UART_RX = 1'b1;
    repeat (BIT / 2) @(negedge CLK);
    #1 RST_N = 1'b0;
    #1 check_reset_outputs("reset_mid_byte");
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset_mid_byte_hold");
    RST_N = 1'b1;
    rx_ready = 1'b1;
    clear_log();
    idle(20);
    send_frame(8'h54, 1'b1, e0);
    idle(10);
    n_checks++;
    if (rise_cyc - e0 != LAT) begin
      n_errs++;
      $display("FAIL reset_recover latency: got %0d expected %0d", rise_cyc - e0, LAT);
    end
    exp_q = '{8'h54};
    check_hs("reset_recover", exp_q);
    check_pulses("reset_recover", 0, 0);
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_single();
    test_string();
    test_glitch();
    test_framing();
    test_overrun();
    test_reset_mid_byte();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
